// File: rtl/ram8_bist_engine_pkg.sv
// ram8_bist_engine_pkg
//   Shared definitions for the RAM8 BIST engine: FSM state encoding, default
//   seed pattern and phase decode helpers used by the engine and its pattern
//   generator.
package ram8_bist_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_RD0  = 3'd2,
    S_WR1  = 3'd3,
    S_RD1  = 3'd4,
    S_DONE = 3'd5,
    S_FAIL = 3'd6
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hABCD;

  // Write phases drive the RAM load strobe.
  function automatic logic phase_is_write(input state_t s);
    return (s == S_WR0) || (s == S_WR1);
  endfunction

  // Read phases compare RAM output against the expected word.
  function automatic logic phase_is_read(input state_t s);
    return (s == S_RD0) || (s == S_RD1);
  endfunction

  // Second pass uses the bitwise-inverted pattern.
  function automatic logic phase_is_inv(input state_t s);
    return (s == S_WR1) || (s == S_RD1);
  endfunction

endpackage

// File: rtl/ram8_bist_pattern_gen.sv
// bist_pattern_gen
//   Combinational expected-word generator: word = SEED + addr (addr
//   zero-extended, carry discarded), optionally bitwise inverted.
//   Shared by the write data path and the read comparator.
// Ports
//   addr_i    in  ADDR_W  current RAM address
//   seed_i    in  DATA_W  base pattern
//   invert_i  in  1       1 = return inverted pattern
//   word_o    out DATA_W  expected word
module bist_pattern_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              invert_i,
  output logic [DATA_W-1:0] word_o
);

  logic [DATA_W-1:0] sum;

  assign sum    = seed_i + DATA_W'(addr_i);
  assign word_o = invert_i ? ~sum : sum;

endmodule

// File: rtl/ram8_bist_engine.sv
// ram8_bist_engine
//   Built-in self-test initiator for the 8-word register RAM. Writes
//   SEED+addr to every word, reads it back, writes the inverted pattern,
//   reads that back and reports pass/fail. Muxed onto the RAM port while
//   busy=1.
// Configuration macro
//   BIST_ERR_COUNT_EN : adds err_count output; mismatches are counted
//                       (saturating) instead of aborting, first mismatch kept.
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       run request, honoured only when busy=0
//   busy       out  1       test in progress
//   done       out  1       test finished (held until next start/reset)
//   pass       out  1       valid with done; 1 = no mismatch
//   fail_addr  out  ADDR_W  address of first mismatch
//   fail_data  out  DATA_W  data read at first mismatch
//   mem_in     out  DATA_W  RAM write data
//   mem_addr   out  ADDR_W  RAM address
//   mem_load   out  1       RAM write enable
//   mem_out    in   DATA_W  RAM read data (combinational)
//   err_count  out  ADDR_W+2 mismatch count (BIST_ERR_COUNT_EN only)
module ram8_bist_engine
  import ram8_bist_engine_pkg::*;
#(
  parameter int unsigned       DATA_W = 16,
  parameter int unsigned       ADDR_W = 3,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
`ifdef BIST_ERR_COUNT_EN
  ,
  output logic [ADDR_W+1:0] err_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
`ifdef BIST_ERR_COUNT_EN
  logic [ADDR_W+1:0] err_q, err_d;
`endif

  logic [DATA_W-1:0] exp_word;
  logic              last_addr;
  logic              mismatch;

  bist_pattern_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_pattern (
    .addr_i   (addr_q),
    .seed_i   (SEED),
    .invert_i (phase_is_inv(state_q)),
    .word_o   (exp_word)
  );

  assign last_addr = (addr_q == LAST_ADDR);
  assign mismatch  = phase_is_read(state_q) && (mem_out != exp_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
`ifdef BIST_ERR_COUNT_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
`ifdef BIST_ERR_COUNT_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
`ifdef BIST_ERR_COUNT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      S_WR0, S_WR1: begin
        // Counter wraps to 0 at LAST_ADDR, so the next phase starts at addr 0.
        addr_d = addr_q + ADDR_W'(1);
        if (last_addr) state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
      end
      S_RD0, S_RD1: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_addr) state_d = (state_q == S_RD0) ? S_WR1 : S_DONE;
`ifdef BIST_ERR_COUNT_EN
        if (mismatch) begin
          if (err_q == '0) begin
            fail_addr_d = addr_q;
            fail_data_d = mem_out;
          end
          if (err_q != '1) err_d = err_q + (ADDR_W+2)'(1);
        end
        // Final compare folds in its own result as well as earlier ones.
        if (last_addr && (state_q == S_RD1) && (mismatch || (err_q != '0)))
          state_d = S_FAIL;
`else
        if (mismatch) begin
          fail_addr_d = addr_q;
          fail_data_d = mem_out;
          state_d     = S_FAIL;
          addr_d      = '0;
        end
`endif
      end
      default: begin
        // IDLE, DONE, FAIL: idle states that accept a new run.
        if (start) begin
          state_d     = S_WR0;
          addr_d      = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
`ifdef BIST_ERR_COUNT_EN
          err_d       = '0;
`endif
        end
      end
    endcase
  end

  assign busy      = phase_is_write(state_q) || phase_is_read(state_q);
  assign done      = (state_q == S_DONE) || (state_q == S_FAIL);
  assign pass      = (state_q == S_DONE);
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign mem_load  = phase_is_write(state_q);
  assign mem_addr  = addr_q;
  assign mem_in    = mem_load ? exp_word : '0;
`ifdef BIST_ERR_COUNT_EN
  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_ram8_bist_engine.sv
module tb_ram8_bist_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic        busy0, done0, pass0, load0;
  logic        busy1, done1, pass1, load1;
  logic [2:0]  faddr0, addr0, faddr1, addr1;
  logic [15:0] fdata0, min0, mout0, fdata1, min1, mout1;
`ifdef BIST_ERR_COUNT_EN
  logic [4:0]  err0, err1;
`endif

  logic [15:0] ram0 [8];
  logic [15:0] ram1 [8];
  logic [15:0] and0 [8];
  logic [15:0] or0  [8];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n;

  localparam logic [15:0] WR0_TAB [8] = '{16'hABCD, 16'hABCE, 16'hABCF, 16'hABD0,
                                          16'hABD1, 16'hABD2, 16'hABD3, 16'hABD4};
  localparam logic [15:0] WR1_TAB [8] = '{16'h5432, 16'h5431, 16'h5430, 16'h542F,
                                          16'h542E, 16'h542D, 16'h542C, 16'h542B};
  localparam logic [15:0] WRS_TAB [8] = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
                                          16'h0000, 16'h0001, 16'h0002, 16'h0003};

  always #5 clk = ~clk;

  ram8_bist_engine dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_addr(faddr0), .fail_data(fdata0), .mem_in(min0), .mem_addr(addr0),
    .mem_load(load0), .mem_out(mout0)
`ifdef BIST_ERR_COUNT_EN
    , .err_count(err0)
`endif
  );

  ram8_bist_engine #(.DATA_W(16), .ADDR_W(3), .SEED(16'hFFFC)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_addr(faddr1), .fail_data(fdata1), .mem_in(min1), .mem_addr(addr1),
    .mem_load(load1), .mem_out(mout1)
`ifdef BIST_ERR_COUNT_EN
    , .err_count(err1)
`endif
  );

  // RAM models; dut0's read path can inject stuck bits per word.
  always @(posedge clk) if (load0) ram0[addr0] <= min0;
  always @(posedge clk) if (load1) ram1[addr1] <= min1;
  assign mout0 = (ram0[addr0] & and0[addr0]) | or0[addr0];
  assign mout1 = ram1[addr1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  // Counts busy cycles from the current cycle, bounded.
  task automatic count_busy(input string tag, input int unsigned exp);
    int unsigned k = 0;
    while (busy0 === 1'b1 && k < 200) begin
      k++;
      @(negedge clk);
    end
    chk(tag, k, exp);
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      and0[i] = 16'hFFFF; or0[i] = 16'h0000; ram0[i] = 16'h0; ram1[i] = 16'h0;
    end
    #12;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_load", load0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Full good run: per-cycle bus check.
    pulse0();
    for (int c = 0; c < 32; c++) begin
      chk("run_busy", busy0, 1);
      chk("run_done", done0, 0);
      if (c < 8) begin
        chk("wr0_load", load0, 1);
        chk("wr0_addr", addr0, 32'(c));
        chk("wr0_data", min0, WR0_TAB[c]);
      end else if (c >= 16 && c < 24) begin
        chk("wr1_load", load0, 1);
        chk("wr1_addr", addr0, 32'(c - 16));
        chk("wr1_data", min0, WR1_TAB[c - 16]);
      end else begin
        chk("rd_load", load0, 0);
      end
      @(negedge clk);
    end
    chk("good_busy", busy0, 0);
    chk("good_done", done0, 1);
    chk("good_pass", pass0, 1);
    chk("good_faddr", faddr0, 0);
    chk("good_fdata", fdata0, 0);
    chk("good_addr", addr0, 0);
`ifdef BIST_ERR_COUNT_EN
    chk("good_err", err0, 0);
`endif

    // Starts during busy (cycles 5, 20 and final compare) ignored.
    @(negedge clk); start0 = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy0 === 1'b1 && n < 200) begin
      start0 = (n == 5 || n == 20 || n == 31);
      n++;
      @(negedge clk);
    end
    start0 = 1'b0;
    chk("ign_len", n, 32);
    chk("ign_done", done0, 1);
    chk("ign_pass", pass0, 1);
    chk("ign_busy", busy0, 0);

    // Start in DONE reruns; done clears next cycle.
    start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    chk("rerun_done", done0, 0);
    chk("rerun_busy", busy0, 1);
    count_busy("rerun_len", 32);
    chk("rerun_pass", pass0, 1);

    // Word 3 reads as 0000: abort in RD0 at addr 3.
    and0[3] = 16'h0000;
    pulse0();
`ifdef BIST_ERR_COUNT_EN
    count_busy("stuck_len", 32);
    chk("stuck_err", err0, 2);
`else
    count_busy("stuck_len", 12);
`endif
    chk("stuck_done", done0, 1);
    chk("stuck_pass", pass0, 0);
    chk("stuck_faddr", faddr0, 3);
    chk("stuck_fdata", fdata0, 16'h0000);
    chk("stuck_load", load0, 0);
    and0[3] = 16'hFFFF;

    // Bit15 stuck-at-1 at addr 6: only RD1 fails.
    or0[6] = 16'h8000;
    pulse0();
    chk("clr_faddr", faddr0, 0);
    chk("clr_fdata", fdata0, 0);
`ifdef BIST_ERR_COUNT_EN
    count_busy("inv_len", 32);
    chk("inv_err", err0, 1);
`else
    count_busy("inv_len", 31);
`endif
    chk("inv_done", done0, 1);
    chk("inv_pass", pass0, 0);
    chk("inv_faddr", faddr0, 6);
    chk("inv_fdata", fdata0, 16'hD42C);
    or0[6] = 16'h0000;

    // Reset mid-WR0 at addr 5.
    pulse0();
    repeat (5) @(negedge clk);
    chk("mid_addr", addr0, 5);
    chk("mid_load", load0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_done", done0, 0);
    chk("arst_pass", pass0, 0);
    chk("arst_load", load0, 0);
    chk("arst_addr", addr0, 0);
    chk("arst_min", min0, 0);
    chk("arst_faddr", faddr0, 0);
    chk("arst_fdata", fdata0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy0, 0);
    chk("idle_done", done0, 0);

    // Seed wrap on the second instance.
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 0; c < 32; c++) begin
      chk("s_busy", busy1, 1);
      if (c < 8) chk("s_wr0_data", min1, WRS_TAB[c]);
      @(negedge clk);
    end
    chk("s_done", done1, 1);
    chk("s_pass", pass1, 1);
    chk("s_faddr", faddr1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
